// File: rtl/lc3_ctrl_hs.sv
// lc3_ctrl_hs -- multicycle LC-3 control unit with a ready/valid memory handshake.
//
// Sequences the bus-based LC-3 datapath (PC, EAB, MARMUX, regfile, ALU, NZP,
// IR, MAR/MDR, tri-state bus drivers). Memory accesses have variable latency.
// Each access waits for mem_rdy, and a wait-state timeout parks the core in a
// sticky fault. TRAP to HALT_VEC parks the core in a sticky halt. instr_done
// pulses in the last cycle of every instruction.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ir[15:0], n, z, p        instruction register, condition flags
//   mem_rdy                  memory accepted write / read data valid
//   mem_en, mem_we           memory request (held until mem_rdy), write qualifier
//   ld_mar, ld_mdr, sel_mdr  MAR/MDR load, MDR source (1 = memory, 0 = bus)
//   ld_ir, ld_pc, sel_pc     IR load, PC load, PC mux (00 PC+1, 01 EAB, 10 bus)
//   sel_eab1, sel_eab2       EAB base (0 PC, 1 SR1), offset (00 0, 01 off6, 10 off9, 11 off11)
//   sel_marm                 MARMUX (0 EAB, 1 zext(ir[7:0]))
//   ena_pc/mdr/alu/marm      bus drivers, at most one high per cycle
//   reg_we, flag_we          regfile write, NZP update
//   dr, sr1, sr2, alu_ctrl   register addresses, ALU op (00 ADD, 01 AND, 10 NOT, 11 PASS-A)
//   instr_done, halted, bus_err  retire pulse, sticky halt, sticky bus fault
//
// Optional feature (macro LC3_CTRL_PERF_EN): adds cyc_cnt / ret_cnt
// performance counters of width CNT_W.

module lc3_ctrl_hs #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [7:0]  HALT_VEC    = 8'h25
`ifdef LC3_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W       = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_rdy,
    output logic        mem_en,
    output logic        mem_we,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        sel_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic [1:0]  sel_pc,
    output logic        sel_eab1,
    output logic [1:0]  sel_eab2,
    output logic        sel_marm,
    output logic        ena_pc,
    output logic        ena_mdr,
    output logic        ena_alu,
    output logic        ena_marm,
    output logic        reg_we,
    output logic        flag_we,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [1:0]  alu_ctrl,
    output logic        instr_done,
    output logic        halted,
    output logic        bus_err
`ifdef LC3_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
                           OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
                           OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
                           OP_JMP = 4'hC, OP_RSV = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_FET0, S_FET1, S_FET2, S_DECODE,
        S_EXE, S_LEA, S_BR, S_JMP, S_JSR1, S_JSR2,
        S_ADDR, S_IND_RD, S_IND_TA, S_IND_MAR,
        S_RD, S_RD_TA, S_WB, S_SD, S_WR,
        S_TRAP0, S_TRAP1, S_TRAP2,
        S_HALT, S_FAULT
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       mem_wait;
    logic [3:0] op;
    logic       take_br;

    assign op        = ir[15:12];
    assign take_br   = (n & ir[11]) | (z & ir[10]) | (p & ir[9]);
    assign mem_state = (state == S_FET1) || (state == S_IND_RD) || (state == S_RD) ||
                       (state == S_WR)   || (state == S_TRAP1);
    assign mem_wait  = mem_state && !mem_rdy;

    // Next-state and wait counter. The counter is zero whenever an access is
    // not stalled, so every memory state is entered with a cleared count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FET0;
            wait_cnt <= '0;
        end else if (mem_wait) begin
            if (wait_cnt == WAIT_LAST) begin
                state    <= S_FAULT;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= '0;
            case (state)
                S_FET0:   state <= S_FET1;
                S_FET1:   state <= S_FET2;
                S_FET2:   state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_BR:                          state <= S_BR;
                        OP_ADD, OP_AND, OP_NOT:         state <= S_EXE;
                        OP_LD, OP_ST, OP_LDR, OP_STR,
                        OP_LDI, OP_STI:                 state <= S_ADDR;
                        OP_JSR:                         state <= S_JSR1;
                        OP_JMP:                         state <= S_JMP;
                        OP_LEA:                         state <= S_LEA;
                        OP_TRAP:                        state <= S_TRAP0;
                        default:                        state <= S_FET0;  // RTI, reserved
                    endcase
                end
                S_ADDR: begin
                    if (op == OP_LDI || op == OP_STI)   state <= S_IND_RD;
                    else if (op == OP_LD || op == OP_LDR) state <= S_RD;
                    else                                state <= S_SD;
                end
                S_IND_RD:  state <= S_IND_TA;
                S_IND_TA:  state <= S_IND_MAR;
                S_IND_MAR: state <= (op == OP_LDI) ? S_RD : S_SD;
                S_RD:      state <= S_RD_TA;
                S_RD_TA:   state <= S_WB;
                S_SD:      state <= S_WR;
                S_JSR1:    state <= S_JSR2;
                S_TRAP0:   state <= S_TRAP1;
                S_TRAP1:   state <= S_TRAP2;
                S_TRAP2:   state <= (ir[7:0] == HALT_VEC) ? S_HALT : S_FET0;
                S_HALT:    state <= S_HALT;
                S_FAULT:   state <= S_FAULT;
                default:   state <= S_FET0;   // EXE, LEA, BR, JMP, JSR2, WB, WR
            endcase
        end
    end

    // Control outputs: decoded from state and ir, plus mem_rdy in the memory
    // states so loads and retire happen in the accepting cycle. Reset forces
    // everything low, which drops an in-flight request at once.
    always_comb begin
        // NOTE: every output is defaulted before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        mem_en = 1'b0;  mem_we = 1'b0;  ld_mar = 1'b0;  ld_mdr = 1'b0;
        sel_mdr = 1'b0; ld_ir = 1'b0;   ld_pc = 1'b0;   sel_pc = 2'b00;
        sel_eab1 = 1'b0; sel_eab2 = 2'b00; sel_marm = 1'b0;
        ena_pc = 1'b0;  ena_mdr = 1'b0; ena_alu = 1'b0; ena_marm = 1'b0;
        reg_we = 1'b0;  flag_we = 1'b0;
        dr = 3'd0;      sr1 = 3'd0;     sr2 = 3'd0;     alu_ctrl = 2'b00;
        instr_done = 1'b0; halted = 1'b0; bus_err = 1'b0;
        if (!rst) begin
            case (state)
                S_FET0: begin ena_pc = 1'b1; ld_mar = 1'b1; end
                S_FET1: begin
                    mem_en = 1'b1; sel_mdr = 1'b1;
                    ld_mdr = mem_rdy; ld_pc = mem_rdy;      // PC <- PC+1
                end
                S_FET2:   begin ena_mdr = 1'b1; ld_ir = 1'b1; end
                S_DECODE: instr_done = (op == OP_RTI) || (op == OP_RSV);
                S_EXE: begin
                    ena_alu = 1'b1; reg_we = 1'b1; flag_we = 1'b1;
                    dr = ir[11:9]; sr1 = ir[8:6]; sr2 = ir[2:0];
                    alu_ctrl = (op == OP_ADD) ? 2'b00 : (op == OP_AND) ? 2'b01 : 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDR: begin
                    ena_marm = 1'b1; ld_mar = 1'b1;
                    if (op == OP_LDR || op == OP_STR) begin
                        sel_eab1 = 1'b1; sel_eab2 = 2'b01; sr1 = ir[8:6];
                    end else begin
                        sel_eab2 = 2'b10;
                    end
                end
                S_IND_RD, S_RD: begin mem_en = 1'b1; sel_mdr = 1'b1; ld_mdr = mem_rdy; end
                S_IND_MAR: begin ena_mdr = 1'b1; ld_mar = 1'b1; end
                S_WB: begin
                    ena_mdr = 1'b1; reg_we = 1'b1; flag_we = 1'b1; dr = ir[11:9];
                    instr_done = 1'b1;
                end
                S_SD: begin ena_alu = 1'b1; alu_ctrl = 2'b11; sr1 = ir[11:9]; ld_mdr = 1'b1; end
                S_WR: begin mem_en = 1'b1; mem_we = 1'b1; instr_done = mem_rdy; end
                S_BR: begin
                    sel_pc = 2'b01; sel_eab2 = 2'b10; ld_pc = take_br; instr_done = 1'b1;
                end
                S_JMP: begin
                    sel_pc = 2'b01; sel_eab1 = 1'b1; sr1 = ir[8:6]; ld_pc = 1'b1;
                    instr_done = 1'b1;
                end
                S_JSR1: begin ena_pc = 1'b1; reg_we = 1'b1; dr = 3'd7; end
                S_JSR2: begin
                    sel_pc = 2'b01; ld_pc = 1'b1; instr_done = 1'b1;
                    if (ir[11]) sel_eab2 = 2'b11;
                    else begin sel_eab1 = 1'b1; sr1 = ir[8:6]; end
                end
                S_LEA: begin
                    sel_eab2 = 2'b10; ena_marm = 1'b1; reg_we = 1'b1; flag_we = 1'b1;
                    dr = ir[11:9]; instr_done = 1'b1;
                end
                S_TRAP0: begin sel_marm = 1'b1; ena_marm = 1'b1; ld_mar = 1'b1; end
                S_TRAP1: begin
                    mem_en = 1'b1; sel_mdr = 1'b1;
                    ld_mdr = mem_rdy; ena_pc = mem_rdy; reg_we = mem_rdy; dr = 3'd7;
                end
                S_TRAP2: begin
                    ena_mdr = 1'b1; sel_pc = 2'b10; ld_pc = 1'b1; instr_done = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: bus_err = 1'b1;
                default: ;  // S_IND_TA, S_RD_TA: MDR turnaround after a data read
            endcase
        end
    end

`ifdef LC3_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != S_HALT && state != S_FAULT) cyc_cnt <= cyc_cnt + 1'b1;
            if (instr_done)                          ret_cnt <= ret_cnt + 1'b1;
        end
    end
`endif

endmodule
